// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity modes, default
// baud constants (shared with the transmitter) and a parity helper.
package uart_pkg;

  // 50 MHz / 115200 baud / 16x oversampling ~= 27 clk per tick
  localparam int unsigned DEFAULT_CLK_DIV    = 27;
  localparam int unsigned DEFAULT_OVERSAMPLE = 16;

  // Parity modes (value of the PARITY_ODD parameter)
  localparam logic PARITY_MODE_EVEN = 1'b0;
  localparam logic PARITY_MODE_ODD  = 1'b1;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // True when the data XOR and the received parity bit disagree with the mode
  function automatic logic parity_error(input logic odd_mode,
                                        input logic data_xor,
                                        input logic parity_bit);
    logic ones_odd;
    ones_odd = data_xor ^ parity_bit;
    return (odd_mode == PARITY_MODE_ODD) ? ~ones_odd : ones_odd;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Received-word handshake bundle between the UART receiver and its consumer.
//   data_out   : received word
//   data_valid : data_out and flags hold a word
//   data_ready : consumer accepts the word when high with data_valid
//   parity_err : parity mismatch for the held word
//   frame_err  : stop bit sampled low for the held word
interface uart_rx_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;
  logic                 parity_err;
  logic                 frame_err;

  modport master (
    output data_out,
    output data_valid,
    output parity_err,
    output frame_err,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    input  parity_err,
    input  frame_err,
    output data_ready
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Clock-divider tick generator. Counts 0..CLK_DIV-1 and pulses tick_c for one
// clk at the terminal count. restart holds the counter at 0 so the tick phase
// aligns with whatever event releases it.
//   clk, reset : system clock, synchronous active-high reset
//   restart    : hold counter at 0 (no ticks while high)
//   tick_c     : one-clk tick pulse (combinational from the counter)
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick_c
);

  localparam int unsigned CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned LAST_CNT = CLK_DIV - 1;

  logic [CNT_W-1:0] cnt_q;

  // Divider counter
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_W'(LAST_CNT)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tick_c = !restart && (cnt_q == CNT_W'(LAST_CNT));

endmodule

// File: rtl/uart_rx.sv
// UART receiver with N-times oversampling. Synchronises rx_in, detects the
// start edge, samples each bit at its midpoint, checks optional parity and the
// stop bit, and presents each word on a valid/ready holding register.
//   clk, reset    : system clock, synchronous active-high reset
//   rx_in         : asynchronous serial line, idles high
//   rx_bus        : received word handshake (data/valid/ready/error flags)
//   overrun       : sticky, a completed frame was dropped (holding reg full)
//   clear_overrun : one-clk pulse clears overrun (a same-clk set wins)
//   busy          : receiver is not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      rx_in,
  uart_rx_if.master rx_bus,
  output logic      overrun,
  input  logic      clear_overrun,
  output logic      busy
);

  localparam int unsigned PH_W     = $clog2(OVERSAMPLE);
  localparam int unsigned BC_W     = $clog2(DATA_BITS + 1);
  localparam int unsigned HALF_PH  = OVERSAMPLE / 2 - 1;
  localparam int unsigned LAST_PH  = OVERSAMPLE - 1;
  localparam int unsigned LAST_BIT = DATA_BITS - 1;
  localparam logic        ODD_MODE = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;
  localparam logic        HAS_PAR  = (PARITY_EN != 0);

  // Synchroniser and edge detect
  logic rx_meta;
  logic rx_s;
  logic rx_prev;
  logic fall_c;

  // FSM state and datapath registers
  rx_state_e            state_q,   state_d;
  logic [PH_W-1:0]      phase_q,   phase_d;
  logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q,   shift_d;
  logic                 par_err_q, par_err_d;

  // Output next-state values
  logic [DATA_BITS-1:0] data_d;
  logic                 valid_d;
  logic                 perr_d;
  logic                 ferr_d;
  logic                 overrun_d;
  logic                 busy_d;

  logic tick_c;
  logic bit_end_c;
  logic frame_done_c;
  logic stop_err_c;
  logic load_c;
  logic consume_c;
  logic ovr_set_c;

  // Tick phase is restarted while idle so it lines up with the start edge
  uart_baud_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (state_q == RX_IDLE),
    .tick_c  (tick_c)
  );

  assign fall_c    = rx_prev && !rx_s;
  assign bit_end_c = tick_c && (phase_q == PH_W'(LAST_PH));

  // Next-state, datapath and output logic
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_err_d    = par_err_q;
    frame_done_c = 1'b0;
    stop_err_c   = 1'b0;

    if (tick_c) begin
      phase_d = (phase_q == PH_W'(LAST_PH)) ? '0 : phase_q + PH_W'(1);
    end

    unique case (state_q)
      RX_IDLE: begin
        phase_d   = '0;
        bit_cnt_d = '0;
        par_err_d = 1'b0;
        if (fall_c) begin
          state_d = RX_START;
        end
      end
      RX_START: begin
        // Mid-start-bit check rejects glitches shorter than half a bit
        if (tick_c && (phase_q == PH_W'(HALF_PH))) begin
          if (rx_s) begin
            state_d = RX_IDLE;
          end else begin
            state_d = RX_DATA;
            phase_d = '0;
          end
        end
      end
      RX_DATA: begin
        if (bit_end_c) begin
          shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BC_W'(1);
          if (bit_cnt_q == BC_W'(LAST_BIT)) begin
            state_d = HAS_PAR ? RX_PARITY : RX_STOP;
          end
        end
      end
      RX_PARITY: begin
        if (bit_end_c) begin
          par_err_d = parity_error(ODD_MODE, ^shift_q, rx_s);
          state_d   = RX_STOP;
        end
      end
      RX_STOP: begin
        if (bit_end_c) begin
          frame_done_c = 1'b1;
          stop_err_c   = !rx_s;
          state_d      = RX_IDLE;
        end
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase

    // Holding register: a completing frame loads if empty or being drained
    consume_c = rx_bus.data_valid && rx_bus.data_ready;
    load_c    = frame_done_c && (!rx_bus.data_valid || rx_bus.data_ready);
    ovr_set_c = frame_done_c && rx_bus.data_valid && !rx_bus.data_ready;

    data_d  = rx_bus.data_out;
    valid_d = rx_bus.data_valid;
    perr_d  = rx_bus.parity_err;
    ferr_d  = rx_bus.frame_err;
    if (load_c) begin
      data_d  = shift_q;
      perr_d  = par_err_q;
      ferr_d  = stop_err_c;
      valid_d = 1'b1;
    end else if (consume_c) begin
      valid_d = 1'b0;
    end

    overrun_d = overrun;
    if (clear_overrun) begin
      overrun_d = 1'b0;
    end
    if (ovr_set_c) begin
      overrun_d = 1'b1;
    end

    busy_d = (state_d != RX_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta           <= 1'b1;
      rx_s              <= 1'b1;
      rx_prev           <= 1'b1;
      state_q           <= RX_IDLE;
      phase_q           <= '0;
      bit_cnt_q         <= '0;
      shift_q           <= '0;
      par_err_q         <= 1'b0;
      rx_bus.data_out   <= '0;
      rx_bus.data_valid <= 1'b0;
      rx_bus.parity_err <= 1'b0;
      rx_bus.frame_err  <= 1'b0;
      overrun           <= 1'b0;
      busy              <= 1'b0;
    end else begin
      rx_meta           <= rx_in;
      rx_s              <= rx_meta;
      rx_prev           <= rx_s;
      state_q           <= state_d;
      phase_q           <= phase_d;
      bit_cnt_q         <= bit_cnt_d;
      shift_q           <= shift_d;
      par_err_q         <= par_err_d;
      rx_bus.data_out   <= data_d;
      rx_bus.data_valid <= valid_d;
      rx_bus.parity_err <= perr_d;
      rx_bus.frame_err  <= ferr_d;
      overrun           <= overrun_d;
      busy              <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: one 8N1 instance and one 8E1 instance,
// CLK_DIV=4, OVERSAMPLE=16 (64 clk per bit). Expected words come from a
// frame-level model (data, parity by popcount, stop bit level).
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned CD  = 4;
  localparam int unsigned OS  = 16;
  localparam int unsigned BIT = CD * OS;

  typedef struct {
    logic [7:0]  d;
    logic        pe;
    logic        fe;
    int unsigned c;
  } word_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic rx_a  = 1'b1;
  logic rx_p  = 1'b1;
  logic clr_a = 1'b0;
  logic clr_p = 1'b0;
  logic ovr_a, ovr_p, busy_a, busy_p;

  int unsigned cyc    = 0;
  int unsigned vcyc_a = 0;
  int          tests  = 0;
  int          fails  = 0;
  word_t       acc_a[$];
  word_t       acc_p[$];

  uart_rx_if #(.DATA_BITS(8)) bus_a ();
  uart_rx_if #(.DATA_BITS(8)) bus_p ();

  uart_rx #(
    .CLK_DIV(CD), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)
  ) dut_a (
    .clk(clk), .reset(reset), .rx_in(rx_a), .rx_bus(bus_a),
    .overrun(ovr_a), .clear_overrun(clr_a), .busy(busy_a)
  );

  uart_rx #(
    .CLK_DIV(CD), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)
  ) dut_p (
    .clk(clk), .reset(reset), .rx_in(rx_p), .rx_bus(bus_p),
    .overrun(ovr_p), .clear_overrun(clr_p), .busy(busy_p)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted word (valid & ready at the accepting edge)
  always @(posedge clk) begin
    if (!reset) begin
      if (bus_a.data_valid) vcyc_a <= vcyc_a + 1;
      if (bus_a.data_valid && bus_a.data_ready)
        acc_a.push_back(word_t'{d: bus_a.data_out, pe: bus_a.parity_err, fe: bus_a.frame_err, c: cyc});
      if (bus_p.data_valid && bus_p.data_ready)
        acc_p.push_back(word_t'{d: bus_p.data_out, pe: bus_p.parity_err, fe: bus_p.frame_err, c: cyc});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame-level reference: {data, parity_err, frame_err}
  function automatic logic [9:0] model(input logic [7:0] d, input bit par_en,
                                       input logic pbit, input logic stop);
    logic pe;
    pe = par_en ? ((($countones(d) + int'(pbit)) % 2) != 0) : 1'b0;
    return {d, pe, ~stop};
  endfunction

  task automatic drive(input bit sel, input logic v, input int unsigned n);
    if (sel) rx_p = v; else rx_a = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                            input logic pbit, input logic stop, output int unsigned t0);
    t0 = cyc;
    drive(sel, 1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(sel, d[i], BIT);
    if (has_par) drive(sel, pbit, BIT);
    drive(sel, stop, BIT);
  endtask

  // Expect exactly one pending accepted word and compare it with the model
  task automatic expect_word(input string tag, input bit sel, input logic [9:0] m,
                             output int unsigned c);
    word_t w;
    int    n;
    c = 0;
    n = sel ? acc_p.size() : acc_a.size();
    check({tag, "_count"}, 32'(n), 32'(1));
    if (n > 0) begin
      w = sel ? acc_p.pop_front() : acc_a.pop_front();
      c = w.c;
      check({tag, "_data"}, 32'(w.d), 32'(m[9:2]));
      check({tag, "_perr"}, 32'(w.pe), 32'(m[1]));
      check({tag, "_ferr"}, 32'(w.fe), 32'(m[0]));
    end
  endtask

  initial begin
    int unsigned t0;
    int unsigned tc;
    int unsigned v0;
    logic [7:0]  rd;
    logic        rs;
    logic        rp;

    bus_a.data_ready = 1'b1;
    bus_p.data_ready = 1'b1;
    repeat (4) @(negedge clk);

    // Reset state
    check("rst_data",  32'(bus_a.data_out), 32'(0));
    check("rst_valid", 32'(bus_a.data_valid), 32'(0));
    check("rst_perr",  32'(bus_a.parity_err), 32'(0));
    check("rst_ferr",  32'(bus_a.frame_err), 32'(0));
    check("rst_ovr",   32'(ovr_a), 32'(0));
    check("rst_busy",  32'(busy_a), 32'(0));
    check("rst_valid_p", 32'(bus_p.data_valid), 32'(0));
    reset = 1'b0;
    repeat (8) @(negedge clk);

    // 8N1 0xA5, single-cycle valid with ~9.5 bit latency from the start edge
    v0 = vcyc_a;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, t0);
    drive(1'b0, 1'b1, BIT);
    expect_word("t1", 1'b0, model(8'hA5, 1'b0, 1'b0, 1'b1), tc);
    check("t1_latency", 32'((tc - t0) >= 600 && (tc - t0) <= 620), 32'(1));
    check("t1_valid_cycles", 32'(vcyc_a - v0), 32'(1));
    check("t1_busy", 32'(busy_a), 32'(0));

    // 20-clk glitch: start rejected, no word
    v0 = vcyc_a;
    drive(1'b0, 1'b0, 10);
    check("t2_busy_during", 32'(busy_a), 32'(1));
    drive(1'b0, 1'b0, 10);
    drive(1'b0, 1'b1, 25);
    check("t2_busy_after", 32'(busy_a), 32'(0));
    drive(1'b0, 1'b1, 2 * BIT);
    check("t2_no_valid", 32'(vcyc_a - v0), 32'(0));
    check("t2_no_word", 32'(acc_a.size()), 32'(0));

    // 0x3C with stop low, then break for 3 bits: one word, no retrigger
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, t0);
    drive(1'b0, 1'b0, 3 * BIT);
    check("t3_busy_break", 32'(busy_a), 32'(0));
    expect_word("t3", 1'b0, model(8'h3C, 1'b0, 1'b0, 1'b0), tc);
    drive(1'b0, 1'b1, 2 * BIT);
    check("t3_no_second", 32'(acc_a.size()), 32'(0));
    check("t3_busy_idle", 32'(busy_a), 32'(0));

    // Overrun: hold 0x11, drop 0x22, then drain and clear
    bus_a.data_ready = 1'b0;
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, t0);
    drive(1'b0, 1'b1, BIT);
    check("t4_valid1", 32'(bus_a.data_valid), 32'(1));
    check("t4_ovr_before", 32'(ovr_a), 32'(0));
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, t0);
    drive(1'b0, 1'b1, BIT);
    check("t4_data_held", 32'(bus_a.data_out), 32'(8'h11));
    check("t4_valid2", 32'(bus_a.data_valid), 32'(1));
    check("t4_ovr_set", 32'(ovr_a), 32'(1));
    bus_a.data_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("t4_valid_drop", 32'(bus_a.data_valid), 32'(0));
    expect_word("t4_acc", 1'b0, model(8'h11, 1'b0, 1'b0, 1'b1), tc);
    check("t4_ovr_sticky", 32'(ovr_a), 32'(1));
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    @(negedge clk);
    check("t4_ovr_clear", 32'(ovr_a), 32'(0));

    // Even parity on 0x07: parity bit 0 is wrong, 1 is right
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1, t0);
    drive(1'b1, 1'b1, BIT);
    expect_word("t5_p0", 1'b1, model(8'h07, 1'b1, 1'b0, 1'b1), tc);
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, t0);
    drive(1'b1, 1'b1, BIT);
    expect_word("t5_p1", 1'b1, model(8'h07, 1'b1, 1'b1, 1'b1), tc);

    // Reset in the middle of data bit 4 aborts the frame
    drive(1'b0, 1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, BIT);
    drive(1'b0, 1'b0, BIT / 2);
    reset = 1'b1;
    rx_a  = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t6_data", 32'(bus_a.data_out), 32'(0));
    check("t6_valid", 32'(bus_a.data_valid), 32'(0));
    check("t6_ferr", 32'(bus_a.frame_err), 32'(0));
    check("t6_busy", 32'(busy_a), 32'(0));
    drive(1'b0, 1'b1, 2 * BIT);
    check("t6_no_word", 32'(acc_a.size()), 32'(0));
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, t0);
    drive(1'b0, 1'b1, BIT);
    expect_word("t6_next", 1'b0, model(8'h5A, 1'b0, 1'b0, 1'b1), tc);

    // Random frames on both instances
    for (int k = 0; k < 6; k++) begin
      rd = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      send_frame(1'b0, rd, 1'b0, 1'b0, rs, t0);
      drive(1'b0, 1'b1, 2 * BIT);
      expect_word("rnd_a", 1'b0, model(rd, 1'b0, 1'b0, rs), tc);
    end
    for (int k = 0; k < 6; k++) begin
      rd = 8'($urandom_range(0, 255));
      rp = 1'($urandom_range(0, 1));
      send_frame(1'b1, rd, 1'b1, rp, 1'b1, t0);
      drive(1'b1, 1'b1, 2 * BIT);
      expect_word("rnd_p", 1'b1, model(rd, 1'b1, rp, 1'b1), tc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
